// File: rtl/mlp_mac_array_if.sv
// Handshake and data bundle between the MLP sequencer, the MAC array and the next layer.
// master = upstream/downstream side, slave = the MAC array.
interface mlp_mac_array_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned OUT_WIDTH  = 16
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_last;
  logic [DATA_WIDTH-1:0]           inp;
  logic [NUM_LANES*DATA_WIDTH-1:0] weight;
  logic [NUM_LANES*DATA_WIDTH-1:0] bias;
  logic                            relu_en;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_LANES*OUT_WIDTH-1:0]  mac_out;
  logic [NUM_LANES-1:0]            sat_flag;
  logic                            len_err;

  modport master (
    output in_valid, in_last, inp, weight, bias, relu_en, out_ready,
    input  in_ready, out_valid, mac_out, sat_flag, len_err
  );

  modport slave (
    input  in_valid, in_last, inp, weight, bias, relu_en, out_ready,
    output in_ready, out_valid, mac_out, sat_flag, len_err
  );
endinterface

// File: rtl/mlp_mac_array.sv
// Multi-lane signed MAC: NUM_LANES neurons share one input stream, each with its own weight,
// adding per-lane bias, optional ReLU and output saturation on the terminating beat.
module mlp_mac_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input logic             clk,
  input logic             reset,
  mlp_mac_array_if.slave  bus
);

  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(MAX_LEN) + 1;
  localparam int unsigned RES_WIDTH = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_LEN + 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic signed [RES_WIDTH-1:0] SAT_MAX =
    {{(RES_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [RES_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic [0:0]                     state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]    acc_q [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]    acc_d [NUM_LANES];
  logic [NUM_LANES*OUT_WIDTH-1:0] mac_q, mac_d;
  logic [NUM_LANES-1:0]           sat_q, sat_d;
  logic                           out_valid_q, out_valid_d;
  logic                           len_err_q, len_err_d;

  logic                           in_ready_c, accept_c, first_c, at_max_c, term_c;
  logic signed [ACC_WIDTH-1:0]    base_c  [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]    prod_c  [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]    sum_c   [NUM_LANES];
  logic signed [RES_WIDTH-1:0]    res_c   [NUM_LANES];
  logic [OUT_WIDTH-1:0]           lane_out_c [NUM_LANES];
  logic [NUM_LANES-1:0]           lane_sat_c;

  // Downstream handshake frees the hold slot in the same cycle, so a new beat can ride along.
  assign in_ready_c = (state_q == ST_ACCUM) || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign first_c    = (cnt_q == '0);
  assign at_max_c   = (cnt_q == CNT_WIDTH'(MAX_LEN - 1));
  assign term_c     = accept_c && (bus.in_last || at_max_c);

  // Per-lane accumulate, bias, ReLU and clip.
  always_comb begin
    lane_sat_c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      base_c[i] = acc_q[i];
      if (first_c) base_c[i] = '0;
      prod_c[i] = ACC_WIDTH'($signed(bus.inp)) *
                  ACC_WIDTH'($signed(bus.weight[i*DATA_WIDTH +: DATA_WIDTH]));
      sum_c[i]  = base_c[i] + prod_c[i];
      res_c[i]  = RES_WIDTH'(sum_c[i]) +
                  RES_WIDTH'($signed(bus.bias[i*DATA_WIDTH +: DATA_WIDTH]));
      if (bus.relu_en && res_c[i][RES_WIDTH-1]) res_c[i] = '0;
      lane_out_c[i] = OUT_WIDTH'(res_c[i]);
      if (res_c[i] > SAT_MAX) begin
        lane_out_c[i] = OUT_WIDTH'(SAT_MAX);
        lane_sat_c[i] = 1'b1;
      end else if (res_c[i] < SAT_MIN) begin
        lane_out_c[i] = OUT_WIDTH'(SAT_MIN);
        lane_sat_c[i] = 1'b1;
      end
    end
  end

  // Next-state and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mac_d       = mac_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    len_err_d   = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) acc_d[i] = acc_q[i];

    if (state_q == ST_HOLD && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_ACCUM;
    end

    if (accept_c) begin
      for (int i = 0; i < NUM_LANES; i++) acc_d[i] = sum_c[i];
      if (term_c) begin
        for (int i = 0; i < NUM_LANES; i++) mac_d[i*OUT_WIDTH +: OUT_WIDTH] = lane_out_c[i];
        sat_d       = lane_sat_c;
        out_valid_d = 1'b1;
        len_err_d   = !bus.in_last;
        state_d     = ST_HOLD;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      mac_q       <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mac_q       <= mac_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      len_err_q   <= len_err_d;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.mac_out   = mac_q;
  assign bus.sat_flag  = sat_q;
  assign bus.len_err   = len_err_q;

endmodule

// File: tb/tb_mlp_mac_array.sv
// Scoreboard bench for mlp_mac_array: a vector-level dot-product model feeds an expected-result
// queue, and an independent monitor checks every presented result against it.
module tb_mlp_mac_array;

  localparam int unsigned DW = 8;
  localparam int unsigned NL = 2;
  localparam int unsigned ML = 8;
  localparam int unsigned OW = 16;
  localparam int unsigned VW = NL * DW;

  typedef struct packed {
    logic [NL*OW-1:0] mac;
    logic [NL-1:0]    sat;
    logic             len_err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mlp_mac_array_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .OUT_WIDTH(OW)) bus ();

  mlp_mac_array #(.DATA_WIDTH(DW), .NUM_LANES(NL), .MAX_LEN(ML), .OUT_WIDTH(OW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  int          b_inp[$];
  logic [VW-1:0] b_w[$];
  bit          m_hold = 1'b0;
  bit          prev_v = 1'b0;
  bit          prev_hs = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] pk(input int l0, input int l1);
    pk = {DW'(l1), DW'(l0)};
  endfunction

  // Reference: dot product of the collected vector plus bias, then ReLU and clip.
  function automatic exp_t model_result(input logic [VW-1:0] bias, input bit relu, input bit lerr);
    exp_t   e;
    longint r;
    longint hi, lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    e.mac = '0;
    e.sat = '0;
    e.len_err = lerr;
    for (int l = 0; l < NL; l++) begin
      r = longint'($signed(bias[l*DW +: DW]));
      for (int k = 0; k < b_inp.size(); k++) begin
        logic [VW-1:0] wv;
        wv = b_w[k];
        r += longint'(b_inp[k]) * longint'($signed(wv[l*DW +: DW]));
      end
      if (relu && r < 0) r = 0;
      if (r > hi) begin
        r = hi;
        e.sat[l] = 1'b1;
      end else if (r < lo) begin
        r = lo;
        e.sat[l] = 1'b1;
      end
      e.mac[l*OW +: OW] = r[OW-1:0];
    end
    return e;
  endfunction

  // One clock of stimulus: check handshake against the model, record accepted beats.
  task automatic cycle(output bit acc);
    logic exp_rdy;
    @(negedge clk);
    chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
    exp_rdy = !m_hold || bus.out_ready;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    if (m_hold && bus.out_ready) m_hold = 1'b0;
    if (acc) begin
      b_inp.push_back(int'($signed(bus.inp)));
      b_w.push_back(bus.weight);
      if (bus.in_last || b_inp.size() == int'(ML)) begin
        sb.push_back(model_result(bus.bias, bus.relu_en, !bus.in_last));
        b_inp.delete();
        b_w.delete();
        m_hold = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inp, input logic [VW-1:0] w, input logic [VW-1:0] b,
                       input bit last, input bit relu);
    bus.inp     = DW'(inp);
    bus.weight  = w;
    bus.bias    = b;
    bus.in_last = last;
    bus.relu_en = relu;
  endtask

  task automatic send_beat(input int inp, input logic [VW-1:0] w, input logic [VW-1:0] b,
                           input bit last, input bit relu);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    drive(inp, w, b, last, relu);
    bus.in_valid = 1'b1;
    while (!acc && n < 50) begin
      cycle(acc);
      n++;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_timeout: beat not accepted within 50 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    bus.in_valid = 1'b0;
    repeat (n) cycle(acc);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    b_inp.delete();
    b_w.delete();
    m_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every presented result must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v  = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: out_valid=1 with no result pending at %0t", $time);
          end else begin
            e = sb[0];
            chk("mac_out", 64'(bus.mac_out), 64'(e.mac));
            chk("sat_flag", 64'(bus.sat_flag), 64'(e.sat));
            chk("len_err", 64'(bus.len_err), (!prev_v || prev_hs) ? 64'(e.len_err) : 64'(0));
            if (bus.out_ready) void'(sb.pop_front());
          end
        end else begin
          chk("len_err_idle", 64'(bus.len_err), 64'(0));
        end
        prev_v  = bus.out_valid;
        prev_hs = bus.out_valid && bus.out_ready;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, '0, '0, 1'b0, 1'b0);

    // Reset state
    do_reset();
    chk("rst_mac_out", 64'(bus.mac_out), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_sat_flag", 64'(bus.sat_flag), 64'(0));
    chk("rst_len_err", 64'(bus.len_err), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Basic dot product, without and with ReLU
    for (int rl = 0; rl < 2; rl++) begin
      send_beat(2, pk(1, -1), pk(10, 0), 1'b0, rl[0]);
      send_beat(3, pk(1, -2), pk(10, 0), 1'b0, rl[0]);
      send_beat(4, pk(1, -3), pk(10, 0), 1'b1, rl[0]);
      idle(2);
    end

    // Saturation at both ends
    for (int k = 0; k < 8; k++) send_beat(127, pk(127, 127), '0, k == 7, 1'b0);
    idle(2);
    for (int k = 0; k < 8; k++) send_beat(-128, pk(127, 127), '0, k == 7, 1'b0);
    idle(2);

    // Back-pressure, then a 1-beat vector on the output handshake cycle
    bus.out_ready = 1'b0;
    send_beat(7, pk(3, -5), pk(1, 2), 1'b0, 1'b0);
    send_beat(-9, pk(4, 6), pk(1, 2), 1'b1, 1'b0);
    drive(11, pk(2, 2), pk(0, 0), 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    repeat (5) cycle(acc);
    bus.out_ready = 1'b1;
    send_beat(11, pk(2, 2), pk(0, 0), 1'b1, 1'b0);
    idle(3);

    // Forced termination at MAX_LEN, beat 9 starts a new vector
    for (int k = 0; k < 9; k++) send_beat(1, pk(1, 1), '0, 1'b0, 1'b0);
    send_beat(1, pk(1, 1), '0, 1'b1, 1'b0);
    idle(2);

    // Reset mid-vector discards the partial sums
    send_beat(9, pk(9, 9), '0, 1'b0, 1'b0);
    send_beat(9, pk(9, 9), '0, 1'b0, 1'b0);
    do_reset();
    idle(2);
    send_beat(5, pk(3, 3), '0, 1'b1, 1'b0);
    idle(2);

    // Randomized vectors with input gaps and output back-pressure
    for (int v = 0; v < 250; v++) begin
      bit forced;
      int n;
      forced = ($urandom_range(0, 7) == 0);
      n      = forced ? int'(ML) : int'($urandom_range(1, ML));
      for (int k = 0; k < n; k++) begin
        int g, inp;
        logic [VW-1:0] w;
        g = 0;
        while ($urandom_range(0, 3) == 0 && g < 4) begin
          bus.in_valid  = 1'b0;
          bus.out_ready = ($urandom_range(0, 2) != 0);
          cycle(acc);
          g++;
        end
        if ($urandom_range(0, 3) == 0) begin
          inp = ($urandom_range(0, 1) == 1) ? 127 : -128;
          w   = pk(127, -128);
        end else begin
          inp = int'($signed(DW'($urandom)));
          w   = VW'($urandom);
        end
        drive(inp, w, VW'($urandom), !forced && (k == n - 1), 1'($urandom_range(0, 1)));
        bus.in_valid = 1'b1;
        acc = 1'b0;
        g   = 0;
        while (!acc && g < 100) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          cycle(acc);
          g++;
        end
        if (!acc) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat_timeout: random beat not accepted within 100 cycles");
        end
        bus.in_valid = 1'b0;
      end
    end

    bus.out_ready = 1'b1;
    idle(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_mac_array.md
Name: mlp_mac_array

Overview:
- Multi-lane signed multiply-accumulate engine for the MLP datapath.
- Successor to the single-neuron MAC: NUM_LANES neurons share one input stream, each lane with its own weight.
- Adds runtime vector length via in_last, per-lane bias, optional ReLU and output saturation.
- Uses valid/ready handshakes on both sides so it sits between the input/weight sequencer and the next layer or result buffer.

Parameters:
- DATA_WIDTH, 8: width of signed input, weight and bias elements.
- NUM_LANES, 2: number of parallel neurons (lanes).
- MAX_LEN, 8: maximum vector length. Vectors are 1..MAX_LEN beats.
- OUT_WIDTH, 16: width of each signed, saturated lane result.
- ACC_WIDTH (localparam): 2*DATA_WIDTH + $clog2(MAX_LEN) + 1. Internal accumulator width; it never overflows.

Ports:
- clk, in, 1: clock. All logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block can accept a beat.
- in_last, in, 1: the current beat is the final element of the vector.
- inp, in, DATA_WIDTH: signed input element, shared by all lanes.
- weight, in, NUM_LANES*DATA_WIDTH: signed weights. Lane i uses [i*DATA_WIDTH +: DATA_WIDTH].
- bias, in, NUM_LANES*DATA_WIDTH: signed per-lane bias, sampled on the terminating beat.
- relu_en, in, 1: apply ReLU, sampled on the terminating beat.
- out_valid, out, 1: results valid.
- out_ready, in, 1: downstream accepts the results.
- mac_out, out, NUM_LANES*OUT_WIDTH: signed lane results, packed the same way as weight.
- sat_flag, out, NUM_LANES: per lane, the result was clipped. Valid with out_valid.
- len_err, out, 1: one-cycle pulse when a vector is force-terminated at MAX_LEN.

Behaviour:
- Reset (synchronous, active-high):
  - Accumulators, beat counter, mac_out, sat_flag, out_valid and len_err are cleared to 0.
  - State goes to ACCUM.
  - in_ready is 1 in the first cycle after reset deasserts.
  - Reset mid-vector or mid-output discards all partial and held results with no output.
- States: ACCUM (collecting beats) and HOLD (result presented).
- in_ready = (state==ACCUM) || out_ready. A new vector's first beat may be accepted in the same cycle as the output handshake.
- Beat acceptance:
  - A beat is accepted when in_valid && in_ready.
  - Per lane: acc_i <= (first beat ? 0 : acc_i) + inp*weight_i, using full signed products sign-extended to ACC_WIDTH.
  - The beat counter increments on every accepted beat.
- Vector termination:
  - A vector terminates on an accepted beat with in_last=1, or on the MAX_LEN-th accepted beat without in_last.
  - The second case also pulses len_err=1 for exactly one cycle, aligned with out_valid rising.
- Result formation on the terminating beat, per lane:
  - r = acc_i + inp*weight_i + sign-extended bias_i.
  - If relu_en and r<0, then r = 0.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. sat_flag_i=1 if clipped, else 0.
  - The result is registered into mac_out. out_valid=1 on the next cycle (latency 1 cycle from the last beat). State goes to HOLD.
  - The beat counter clears.
- HOLD state:
  - mac_out and sat_flag are stable while out_valid && !out_ready.
  - On out_ready, out_valid drops next cycle, unless a new vector terminates in that same cycle (1-beat vector), in which case out_valid stays 1 with the new results.
  - Return to ACCUM.
- Accumulators restart cleanly on each vector's first beat; there is no leakage between vectors.
- Idle cycles (in_valid=0) in ACCUM hold the accumulators and counter.

Test Plan:
1. Assert reset for 2 cycles -> mac_out=0, out_valid=0, sat_flag=0, len_err=0. in_ready=1 the cycle after release.
2. Beats inp=2,3,4; lane0 w=1,1,1, bias 10; lane1 w=-1,-2,-3, bias 0; last on beat 3; relu_en=0 -> one cycle later out_valid=1, lane0=19, lane1=-20. Repeat with relu_en=1 -> lane1=0, sat_flag=00.
3. Eight beats inp=127, w=127, last on beat 8 -> lane=32767, sat_flag=1. Eight beats inp=-128, w=127 -> lane=-32768, sat_flag=1.
4. Hold out_ready=0 for 5 cycles after out_valid -> mac_out stable, in_ready=0, offered beats not accepted. Then raise out_ready with in_valid=1 -> that beat is accepted and the next result excludes prior vector sums.
5. Nine beats inp=1, w=1, in_last never set -> after beat 8: out_valid with lane=8 and a 1-cycle len_err pulse. Beat 9 starts a new vector.
6. Reset asserted after 2 beats of a vector -> no out_valid. A subsequent 1-beat vector inp=5, w=3 -> lane=15.
